// File: rtl/traffic_pkg.sv
// Shared lamp encodings, FSM states and default timing for the highway/country
// intersection controller.
package traffic_pkg;

  localparam logic [1:0] RED    = 2'b00;
  localparam logic [1:0] YELLOW = 2'b01;
  localparam logic [1:0] GREEN  = 2'b10;

  localparam int Y2RDELAY_DEF = 3;
  localparam int R2GDELAY_DEF = 2;
  localparam int CNT_W_DEF    = 4;

  typedef enum logic [2:0] {
    S0 = 3'd0,  // highway green
    S1 = 3'd1,  // highway yellow
    S2 = 3'd2,  // all red
    S3 = 3'd3,  // country green
    S4 = 3'd4   // country yellow
  } state_t;

endpackage

// File: rtl/tc_dwell_timer.sv
// Dwell counter: restarts on load, counts while enabled, flags the terminal count.
module tc_dwell_timer #(
  parameter int CNT_W = 4
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             load,
  input  logic             en,
  input  logic [CNT_W-1:0] tc,
  output logic             done
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clock) begin
    if (clear || load) cnt <= '0;
    else if (en)       cnt <= cnt + 1'b1;
  end

  assign done = (cnt == tc);

endmodule

// File: rtl/traffic_controller.sv
// Moore FSM for the highway/country intersection; lamps decode from state only.
module traffic_controller
  import traffic_pkg::*;
#(
  parameter int Y2RDELAY = Y2RDELAY_DEF,
  parameter int R2GDELAY = R2GDELAY_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  output logic [1:0] hwy,
  output logic [1:0] cntry,
  input  logic       X,
  input  logic       clock,
  input  logic       clear
);

  localparam logic [CNT_W-1:0] Y2R_TC = CNT_W'(Y2RDELAY - 1);
  localparam logic [CNT_W-1:0] R2G_TC = CNT_W'(R2GDELAY - 1);

  state_t           state, state_nxt;
  logic             timed, done, load;
  logic [CNT_W-1:0] tc;

  always_ff @(posedge clock) begin
    if (clear) state <= S0;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S0:      if (X)    state_nxt = S1;
      S1:      if (done) state_nxt = S2;
      S2:      if (done) state_nxt = S3;
      S3:      if (!X)   state_nxt = S4;
      S4:      if (done) state_nxt = S0;
      default:           state_nxt = S0;
    endcase
  end

  // Terminal count depends on which timed state is active; S0/S3 never count.
  always_comb begin
    timed = 1'b0;
    tc    = Y2R_TC;
    case (state)
      S1, S4:  timed = 1'b1;
      S2: begin
        timed = 1'b1;
        tc    = R2G_TC;
      end
      default: timed = 1'b0;
    endcase
  end

  assign load = (state_nxt != state);

  tc_dwell_timer #(.CNT_W(CNT_W)) u_timer (
    .clock (clock),
    .clear (clear),
    .load  (load),
    .en    (timed),
    .tc    (tc),
    .done  (done)
  );

  always_comb begin
    hwy   = RED;
    cntry = RED;
    case (state)
      S0:      hwy   = GREEN;
      S1:      hwy   = YELLOW;
      S3:      cntry = GREEN;
      S4:      cntry = YELLOW;
      default: begin
        hwy   = RED;
        cntry = RED;
      end
    endcase
  end

endmodule

// File: tb/tb_traffic_controller.sv
// Bench for traffic_controller: default-delay DUT and a 1/1-delay DUT share the
// inputs; a phase/countdown model predicts both every cycle.
module tb_traffic_controller;

  logic       clock = 1'b0;
  logic       clear = 1'b1;
  logic       X     = 1'b0;
  logic [1:0] hwy_a, cntry_a, hwy_b, cntry_b;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  traffic_controller dut_a (
    .hwy   (hwy_a),
    .cntry (cntry_a),
    .X     (X),
    .clock (clock),
    .clear (clear)
  );

  traffic_controller #(.Y2RDELAY(1), .R2GDELAY(1), .CNT_W(4)) dut_b (
    .hwy   (hwy_b),
    .cntry (cntry_b),
    .X     (X),
    .clock (clock),
    .clear (clear)
  );

  // phase: 0 hwy green, 1 hwy yellow, 2 all red, 3 country green, 4 country yellow
  typedef struct {
    int phase;
    int left;
  } model_t;

  function automatic model_t step(model_t m, logic x, logic clr, int y2r, int r2g);
    model_t n = m;
    if (clr) begin
      n.phase = 0;
      n.left  = 0;
    end else begin
      case (m.phase)
        0: if (x) begin n.phase = 1; n.left = y2r; end
        1: begin n.left = m.left - 1; if (n.left == 0) begin n.phase = 2; n.left = r2g; end end
        2: begin n.left = m.left - 1; if (n.left == 0) n.phase = 3; end
        3: if (!x) begin n.phase = 4; n.left = y2r; end
        default: begin n.left = m.left - 1; if (n.left == 0) n.phase = 0; end
      endcase
    end
    return n;
  endfunction

  function automatic logic [1:0] lamp_h(int phase);
    case (phase)
      0: return 2'b10;
      1: return 2'b01;
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic [1:0] lamp_c(int phase);
    case (phase)
      3: return 2'b10;
      4: return 2'b01;
      default: return 2'b00;
    endcase
  endfunction

  model_t ma = '{0, 0};
  model_t mb = '{0, 0};
  bit     mvalid = 1'b0;

  always @(posedge clock) begin
    ma = step(ma, X, clear, 3, 2);
    mb = step(mb, X, clear, 1, 1);
    if (clear) mvalid = 1'b1;
  end

  task automatic chk(string name, logic [1:0] act, logic [1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (mvalid) begin
      chk("hwy_a",   hwy_a,   lamp_h(ma.phase));
      chk("cntry_a", cntry_a, lamp_c(ma.phase));
      chk("hwy_b",   hwy_b,   lamp_h(mb.phase));
      chk("cntry_b", cntry_b, lamp_c(mb.phase));
      checks++;
      if ((hwy_a != 2'b00 && cntry_a != 2'b00) || (hwy_b != 2'b00 && cntry_b != 2'b00)) begin
        errors++;
        $display("FAIL conflict at %0t: a=%b/%b b=%b/%b", $time, hwy_a, cntry_a, hwy_b, cntry_b);
      end
    end
  end

  task automatic at(time t);
    #(t - $time);
  endtask

  task automatic cyc(int n);
    repeat (n) @(negedge clock);
  endtask

  initial begin
    // Absolute timeline with default delays.
    at(10);  clear = 1'b0;
    at(11);  chk("rst_hwy", hwy_a, 2'b10); chk("rst_cntry", cntry_a, 2'b00);
    at(60);  X = 1'b1;
    at(66);  chk("t65_hwy", hwy_a, 2'b01); chk("t65_model", lamp_h(ma.phase), 2'b01);
    at(94);  chk("t94_hwy", hwy_a, 2'b01);
    at(96);  chk("t95_hwy", hwy_a, 2'b00); chk("t95_cntry", cntry_a, 2'b00);
    at(116); chk("t115_cntry", cntry_a, 2'b10); chk("t115_model", lamp_c(ma.phase), 2'b10);
    at(260); X = 1'b0;
    at(266); chk("t265_cntry", cntry_a, 2'b01);
    at(296); chk("t295_hwy", hwy_a, 2'b10); chk("t295_cntry", cntry_a, 2'b00);
    at(300);

    // Single-edge reset, then idle for 20 cycles.
    clear = 1'b1; cyc(1); clear = 1'b0;
    cyc(20);
    chk("idle_hwy", hwy_a, 2'b10);

    // One-cycle X pulse: S1(3) S2(2) S3(1) S4(3) -> back to S0 after 9 cycles.
    X = 1'b1; cyc(1); X = 1'b0;
    cyc(5); chk("pulse_s3", cntry_a, 2'b10);
    cyc(1); chk("pulse_s4", cntry_a, 2'b01);
    cyc(3); chk("pulse_s0", hwy_a, 2'b10);
    cyc(3);

    // X held: country green persists; drop one cycle, re-raise.
    X = 1'b1; cyc(30);
    chk("hold_cntry", cntry_a, 2'b10);
    X = 1'b0; cyc(1); X = 1'b1;
    cyc(3); chk("reraise_s0", hwy_a, 2'b10);
    cyc(1); chk("reraise_s1", hwy_a, 2'b01);
    X = 1'b0; cyc(12);

    // Reset mid-S2, then full S1 afterwards.
    X = 1'b1; cyc(5);
    chk("mid_s2", hwy_a, 2'b00);
    clear = 1'b1; cyc(1); clear = 1'b0;
    chk("clr_s2_hwy", hwy_a, 2'b10);
    cyc(1); chk("after_clr_s1", hwy_a, 2'b01);
    cyc(2); chk("after_clr_s1_end", hwy_a, 2'b01);
    cyc(8);

    // Reset mid-S4.
    X = 1'b0; cyc(2);
    chk("mid_s4", cntry_a, 2'b01);
    clear = 1'b1; X = 1'b1; cyc(1); clear = 1'b0;
    chk("clr_s4_hwy", hwy_a, 2'b10); chk("clr_s4_cntry", cntry_a, 2'b00);
    X = 1'b0; cyc(12);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/traffic_controller.md
Name: traffic_controller

Overview:
- Signal controller for a highway / country-road intersection. The highway is green by default.
- A car sensor X on the country road triggers the sequence: highway yellow, then all-red, then country green.
- Country green holds while cars remain. Country yellow then returns priority to the highway.
- Leaf block driven by the system clock; outputs go directly to the lamp drivers.

Parameters:
- Y2RDELAY, 3, number of clock cycles spent in each yellow state (highway yellow and country yellow); must be >= 1.
- R2GDELAY, 2, number of clock cycles spent in the all-red state before country green; must be >= 1.
- CNT_W, 4, width of the internal dwell counter; must hold max(Y2RDELAY, R2GDELAY) - 1.

Ports:
- clock  input  1  system clock; all state changes on the rising edge.
- clear  input  1  synchronous active-high reset.
- X  input  1  country-road car sensor; 1 = car present.
- hwy  output  2  highway lamp: 2'b00 RED, 2'b01 YELLOW, 2'b10 GREEN.
- cntry  output  2  country lamp, same encoding as hwy.
- Positional port order is fixed as (hwy, cntry, X, clock, clear).
- One clock; reset is synchronous and active-high.

Behaviour:
- Moore FSM with a registered state and a dwell counter. Outputs decode from state only; X never affects the outputs combinationally.
- Encoding 2'b11 is never driven.
- S0: hwy=GREEN, cntry=RED.
  - X=1 sampled at an edge -> S1 on that edge.
  - Otherwise remain in S0.
- S1: hwy=YELLOW, cntry=RED.
  - Stay exactly Y2RDELAY cycles, then -> S2.
  - X is ignored.
- S2: hwy=RED, cntry=RED.
  - Stay exactly R2GDELAY cycles, then -> S3.
  - X is ignored.
- S3: hwy=RED, cntry=GREEN.
  - Stay while X=1.
  - The first edge sampling X=0 -> S4.
  - Minimum one cycle in S3.
- S4: hwy=RED, cntry=YELLOW.
  - Stay exactly Y2RDELAY cycles, then -> S0.
  - X is ignored.
- Dwell counter:
  - Cleared to 0 on every state transition.
  - Increments each cycle in a timed state (S1, S2, S4).
  - The transition fires on the edge where counter == DELAY-1.
  - Held at 0 in S0 and S3.
- Reset (clear=1 at an edge) applies in any state, including mid-sequence:
  - state=S0, counter=0, hwy=GREEN, cntry=RED from that edge.
  - Reset dominates X.
- Simultaneous events:
  - X=1 while in S4 does not shorten S4. The FSM returns to S0 and, if X is still 1, leaves S0 on the following edge, so S0 lasts exactly 1 cycle.
  - X toggling during S1 or S2 has no effect. The FSM still reaches S3 and then checks X on the first S3 edge.
- Hwy and cntry are never both non-RED. At most one road is ever non-RED.

Decomposition:
- Package traffic_pkg holds:
  - color constants RED=2'b00, YELLOW=2'b01, GREEN=2'b10;
  - the state enum S0..S4, 3-bit encoding;
  - default delay constants.
- Optional sub-module tc_dwell_timer, containing:
  - the counter;
  - a load/clear input;
  - a terminal-count compare against the selected delay;
  - a done output.
- The FSM stays in traffic_controller.

Test Plan:
1. Reset: clear=1 for 1 edge, X=0 -> hwy=10, cntry=00. They hold for 20 cycles with X=0.
2. Full cycle, defaults, 10 ns clock (first edge at 5 ns), clear released at 10 ns, X=1 at 60 ns, X=0 at 260 ns:
   - 65 ns: hwy=01.
   - 95 ns: hwy=00, cntry=00.
   - 115 ns: cntry=10.
   - 265 ns: cntry=01.
   - 295 ns: hwy=10, cntry=00.
3. X pulse of 1 cycle in S0 -> sequence runs S1(3)/S2(2). S3 lasts 1 cycle because X=0 there, then S4(3), then S0.
4. X held at 1 continuously -> cntry stays GREEN indefinitely. Dropping X gives S4 for exactly 3 cycles, then S0 for 1 cycle, then S1 again if X has been re-raised.
5. Reset mid-S2 and mid-S4: assert clear for 1 edge -> hwy=10, cntry=00 on that edge. The counter restarts, so the next S1 lasts the full 3 cycles.
6. Parameter override Y2RDELAY=1, R2GDELAY=1 -> S1, S2 and S4 each last exactly 1 cycle. The checker confirms no cycle ever has both outputs non-RED.
